// File: rtl/poets_streaming_pkg.sv
// Shared types and constants for the streaming message-memory writer.
package poets_streaming_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_DROP   = 2'd2,
    ST_COMMIT = 2'd3
  } rx_state_e;

  // Header word layout
  localparam int LEN_LSB   = 0;
  localparam int LEN_MSB   = 15;
  localparam int TRUNC_BIT = 16;
  localparam int SEQ_LSB   = 24;
  localparam int SEQ_MSB   = 31;

  // Message memory geometry
  localparam int MEM_WORDS = 5120;
  localparam int MEM_AW    = 13;

  // Byte lanes of the final beat: unused bytes are the upper ones
  function automatic logic [3:0] empty_to_be(input logic [1:0] empty);
    logic [3:0] be;
    case (empty)
      2'd0:    be = 4'hF;
      2'd1:    be = 4'h7;
      2'd2:    be = 4'h3;
      default: be = 4'h1;
    endcase
    return be;
  endfunction

  function automatic logic [2:0] empty_to_bytes(input logic [1:0] empty);
    return 3'd4 - {1'b0, empty};
  endfunction

  function automatic logic [31:0] make_header(input logic [15:0] len,
                                              input logic        trunc,
                                              input logic [7:0]  seq);
    logic [31:0] h;
    h = '0;
    h[LEN_MSB:LEN_LSB] = len;
    h[TRUNC_BIT]       = trunc;
    h[SEQ_MSB:SEQ_LSB] = seq;
    return h;
  endfunction

endpackage

// File: rtl/poets_system_streaming_slot_ctr.sv
// Ring bookkeeping: write head, committed-slot count and release underflow.
module poets_system_streaming_slot_ctr #(
  parameter int NUM_SLOTS = 64,
  parameter int HW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  parameter int CW        = $clog2(NUM_SLOTS) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          advance,
  input  logic          commit,
  input  logic          rel_pulse,
  output logic [HW-1:0] head,
  output logic [CW-1:0] slots_used,
  output logic          full,
  output logic          empty,
  output logic          underflow_err
);

  logic [HW-1:0] head_q, head_d;
  logic [CW-1:0] used_q, used_d;
  logic          uflow_q, uflow_d;

  // Head moves when a header is issued; the count moves on header acceptance and release
  always_comb begin
    head_d  = head_q;
    used_d  = used_q;
    uflow_d = uflow_q;
    if (advance) begin
      head_d = (head_q == HW'(NUM_SLOTS - 1)) ? '0 : head_q + 1'b1;
    end
    case ({commit, rel_pulse})
      2'b10: used_d = used_q + 1'b1;
      2'b01: begin
        if (used_q == '0) uflow_d = 1'b1;
        else              used_d  = used_q - 1'b1;
      end
      default: used_d = used_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      used_q  <= '0;
      uflow_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      used_q  <= used_d;
      uflow_q <= uflow_d;
    end
  end

  assign head          = head_q;
  assign slots_used    = used_q;
  assign full          = (used_q == CW'(NUM_SLOTS));
  assign empty         = (used_q == '0);
  assign underflow_err = uflow_q;

endmodule

// File: rtl/poets_system_streaming_rx_writer.sv
// Avalon-ST to Avalon-MM writer filling a ring of message slots, header last.
module poets_system_streaming_rx_writer #(
  parameter int SLOT_WORDS = 16,
  parameter int NUM_SLOTS  = 64,
  parameter int BASE_ADDR  = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  snk_data,
  input  logic                         snk_valid,
  output logic                         snk_ready,
  input  logic                         snk_startofpacket,
  input  logic                         snk_endofpacket,
  input  logic [1:0]                   snk_empty,
  output logic [12:0]                  avm_address,
  output logic [31:0]                  avm_writedata,
  output logic [3:0]                   avm_byteenable,
  output logic                         avm_write,
  output logic                         avm_chipselect,
  input  logic                         avm_waitrequest,
  input  logic                         rel_pulse,
  output logic [$clog2(NUM_SLOTS):0]   slots_used,
  output logic                         msg_pending,
  output logic [15:0]                  drop_count,
  output logic                         underflow_err
);
  import poets_streaming_pkg::*;

  localparam int HW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS) + 1;
  localparam int BW = $clog2(SLOT_WORDS);

  if (BASE_ADDR + NUM_SLOTS * SLOT_WORDS > MEM_WORDS) begin : g_bad_range
    $error("slot ring does not fit in message memory");
  end
  if (SLOT_WORDS < 2 || (SLOT_WORDS & (SLOT_WORDS - 1)) != 0) begin : g_bad_slot
    $error("SLOT_WORDS must be a power of two and at least 2");
  end
  if (NUM_SLOTS > 256 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_ring
    $error("NUM_SLOTS must be a power of two no larger than 256");
  end

  rx_state_e         state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [15:0]       len_q, len_d;
  logic              trunc_q, trunc_d;
  logic [7:0]        seq_q, seq_d;
  logic              wr_q, wr_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              hdr_pend_q, hdr_pend_d;
  logic [15:0]       drop_q, drop_d;

  logic [HW-1:0]     head;
  logic              full, empty, advance, commit;
  logic              wr_done, accept;
  logic [MEM_AW-1:0] slot_base;
  logic [3:0]        beat_be;
  logic [2:0]        beat_bytes;

  poets_system_streaming_slot_ctr #(
    .NUM_SLOTS (NUM_SLOTS),
    .HW        (HW),
    .CW        (CW)
  ) u_slot_ctr (
    .clk           (clk),
    .reset_n       (reset_n),
    .advance       (advance),
    .commit        (commit),
    .rel_pulse     (rel_pulse),
    .head          (head),
    .slots_used    (slots_used),
    .full          (full),
    .empty         (empty),
    .underflow_err (underflow_err)
  );

  // Packet FSM, write-port register loading and handshake decode
  always_comb begin
    wr_done    = wr_q && !avm_waitrequest;
    snk_ready  = reset_n && (state_q != ST_COMMIT) && !(wr_q && avm_waitrequest);
    accept     = snk_valid && snk_ready;
    slot_base  = MEM_AW'(BASE_ADDR) + MEM_AW'(head) * MEM_AW'(SLOT_WORDS);
    beat_be    = snk_endofpacket ? empty_to_be(snk_empty) : 4'hF;
    beat_bytes = snk_endofpacket ? empty_to_bytes(snk_empty) : 3'd4;

    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    seq_d      = seq_q;
    wr_d       = wr_q && avm_waitrequest;
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    drop_d     = drop_q;
    advance    = 1'b0;
    commit     = hdr_pend_q && wr_done;
    hdr_pend_d = hdr_pend_q && !wr_done;

    case (state_q)
      ST_IDLE: begin
        if (accept && snk_startofpacket) begin
          if (full) begin
            if (snk_endofpacket) begin
              if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            wr_d    = 1'b1;
            addr_d  = slot_base + MEM_AW'(1);
            data_d  = snk_data;
            be_d    = beat_be;
            len_d   = {13'd0, beat_bytes};
            trunc_d = 1'b0;
            beat_d  = BW'(1);
            state_d = snk_endofpacket ? ST_COMMIT : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (accept) begin
          if (beat_q != BW'(SLOT_WORDS - 1)) begin
            wr_d   = 1'b1;
            addr_d = slot_base + MEM_AW'(1) + MEM_AW'(beat_q);
            data_d = snk_data;
            be_d   = beat_be;
            len_d  = len_q + {13'd0, beat_bytes};
            beat_d = beat_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
          if (snk_endofpacket) state_d = ST_COMMIT;
        end
      end
      ST_DROP: begin
        if (accept && snk_endofpacket) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        if (!wr_q || !avm_waitrequest) begin
          wr_d       = 1'b1;
          addr_d     = slot_base;
          data_d     = make_header(len_q, trunc_q, seq_q);
          be_d       = 4'hF;
          hdr_pend_d = 1'b1;
          advance    = 1'b1;
          seq_d      = seq_q + 8'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and write-port registers; reset abandons any partial slot
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      seq_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      hdr_pend_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      len_q      <= len_d;
      trunc_q    <= trunc_d;
      seq_q      <= seq_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      be_q       <= be_d;
      hdr_pend_q <= hdr_pend_d;
      drop_q     <= drop_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = be_q;
  assign avm_write      = wr_q;
  assign avm_chipselect = wr_q;
  assign drop_count     = drop_q;
  assign msg_pending    = !empty;

endmodule

// File: doc/poets_system_streaming_rx_writer.md
# poets_system_streaming_rx_writer

Upstream stage of the streaming system's on-chip message memory. It accepts POETS messages on an Avalon-ST sink and writes each one into a ring of fixed-size slots in the 32-bit, 5120-word memory through an Avalon-MM write master. Each packet's header word is written last, so a consumer never sees a partially written message. A release pulse from the consumer frees slots.

## Interface
- SLOT_WORDS, 16: words per slot. Power of two, ≥2. Word 0 is the header; the rest is payload.
- NUM_SLOTS, 64: ring depth. Power of two, ≤256.
- BASE_ADDR, 0: word address of slot 0. BASE_ADDR + NUM_SLOTS*SLOT_WORDS must be ≤5120. Elaboration fails otherwise.
- clk  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- snk_data  in  32  payload beat. The first byte is in [7:0].
- snk_valid / snk_ready  in / out  1  Avalon-ST handshake
- snk_startofpacket, snk_endofpacket  in  1  packet delimiters
- snk_empty  in  2  count of unused upper bytes; meaningful only on the EOP beat
- avm_address  out  13  memory word address
- avm_writedata  out  32  write data
- avm_byteenable  out  4  byte lanes
- avm_write  out  1  write strobe; the block also drives avm_chipselect equal to it
- avm_waitrequest  in  1  interconnect stall
- rel_pulse  in  1  consumer frees the oldest slot
- slots_used  out  log2(NUM_SLOTS)+1  number of committed slots not yet released
- msg_pending  out  1  high when slots_used≠0
- drop_count  out  16  packets dropped because the ring was full; saturates at 16'hFFFF
- underflow_err  out  1  sticky; set by rel_pulse when slots_used=0

## Operation
- FSM states: IDLE, WRITE, DROP, COMMIT.
- **IDLE:** beats without SOP are accepted and discarded.
  - SOP beat with slots_used<NUM_SLOTS: go to WRITE. Beat 0 goes to payload word 1 of slot `head`.
  - SOP beat with the ring full: go to DROP.
- **WRITE:** beat k is written to BASE_ADDR + head*SLOT_WORDS + 1 + k.
  - Beats beyond SLOT_WORDS-1 are accepted but not written. The truncated flag is set and the byte length stops counting.
  - An SOP inside a packet is treated as an ordinary beat.
  - EOP: go to COMMIT.
- **DROP:** accept and discard beats until EOP. drop_count increments once per dropped packet. Return to IDLE.
- **COMMIT:** write the header to the slot's word 0 with byteenable 4'hF. Then increment head (mod NUM_SLOTS) and the sequence number, and return to IDLE.
- **Header format:** [15:0] byte length of the stored payload; [16] truncated; [23:17] zero; [31:24] 8-bit sequence number, wrapping.
- **Byteenable:** payload words use 4'hF. The EOP beat uses snk_empty 0/1/2/3 → F/7/3/1, and its bytes count as 4−empty.
- **slots_used:** +1 on header write acceptance, −1 on rel_pulse. When both occur in the same cycle it is unchanged. rel_pulse at 0 leaves the count at 0 and sets underflow_err.
- **Reset values:**
  - head, seq, slots_used, drop_count: 0
  - underflow_err: 0
  - avm_write: 0
  - snk_ready: 0 during reset
  - state: IDLE
- Reset mid-packet discards the partial slot; no header is written.

## Timing
- snk_ready = (state≠COMMIT) && !(avm_write && avm_waitrequest). It is combinational from registered state.
- An accepted beat at cycle N drives avm_write with address, data and byteenable at N+1. These are held stable while avm_waitrequest=1.
- EOP accepted at N:
  - last payload write at N+1;
  - header write at N+2 at the earliest;
  - slots_used and msg_pending update at the cycle after the header write is accepted (N+3 with no stall).
- A single-beat packet takes 2 write cycles. Sustained throughput is 1 beat/cycle inside a packet, plus 1 cycle per packet for COMMIT.
- The full check uses the slots_used value at SOP acceptance. A commit completing in the same cycle is not counted.
- rel_pulse affects slots_used the next cycle.

## Structure
- Shared package poets_streaming_pkg holds:
  - the FSM state enum;
  - header field positions (LEN_LSB/MSB, TRUNC_BIT, SEQ_LSB/MSB);
  - the memory depth constant 5120 and address width 13.
- One sub-module, poets_system_streaming_slot_ctr, owns head, slots_used, full/empty, the simultaneous commit/release logic and underflow_err.

## Test plan
- 3-beat packet, empty=2, ring empty, BASE_ADDR=0:
  - writes to addresses 1,2,3 with byteenable F,F,3;
  - header to address 0 = 32'h0000_000A (seq 0, length 10);
  - slots_used=1 at EOP+3.
- 20-beat packet with SLOT_WORDS=16:
  - 15 payload writes;
  - header = 32'h0001_003C (truncated, length 60);
  - snk_ready stays high through all 20 beats.
- Fill 64 slots, then send a 65th packet:
  - no avm_write;
  - drop_count=1;
  - head back at 0;
  - the next packet after one rel_pulse lands in slot 0 with seq=64.
- avm_waitrequest held high 5 cycles mid-packet: snk_ready low, address/data stable, no beat lost.
- rel_pulse coincident with header acceptance at slots_used=3: slots_used stays 3. rel_pulse at 0: underflow_err=1.
- reset_n low for 1 cycle mid-packet: no header write, slots_used=0, next SOP writes to slot 0.
